// File: rtl/jellycore_mem_pkg.sv
// -----------------------------------------------------------------------------
// jellycore_mem_pkg
// Shared types and default widths for the store path between the store queue
// and the L1 data-cache write port.
//   WB_DEPTH_DEFAULT   : default number of commit-buffer entries (power of two)
//   ADDR_WIDTH_DEFAULT : default store address width
//   DATA_WIDTH_DEFAULT : default store data width
//   wb_entry_t         : one buffered store {addr, data} at the default widths
//   wb_state_t         : drain FSM states {WB_IDLE, WB_REQ}
// -----------------------------------------------------------------------------
package jellycore_mem_pkg;

   localparam int WB_DEPTH_DEFAULT   = 4;
   localparam int ADDR_WIDTH_DEFAULT = 32;
   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef struct packed {
      logic [ADDR_WIDTH_DEFAULT-1:0] addr;
      logic [DATA_WIDTH_DEFAULT-1:0] data;
   } wb_entry_t;

   typedef enum logic [0:0] {
      WB_IDLE = 1'b0,
      WB_REQ  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/store_fwd_match.sv
// -----------------------------------------------------------------------------
// store_fwd_match
// Youngest-first priority matcher over the occupied entries of the store
// commit buffer. Only built when STORE_FWD_EN is defined.
// Ports:
//   ent_addr / ent_data : buffer entry array
//   occupied            : per-entry valid mask (includes the entry in flight)
//   tail                : next write slot; tail-1 holds the youngest store
//   ld_addr             : load address to look up
//   hit / data          : youngest matching store's data, zero on no match
// -----------------------------------------------------------------------------
`ifdef STORE_FWD_EN
module store_fwd_match #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0]      ent_addr [DEPTH],
   input  logic [DATA_WIDTH-1:0]      ent_data [DEPTH],
   input  logic [DEPTH-1:0]           occupied,
   input  logic [$clog2(DEPTH)-1:0]   tail,
   input  logic [ADDR_WIDTH-1:0]      ld_addr,
   output logic                       hit,
   output logic [DATA_WIDTH-1:0]      data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hit  = 1'b0;
      data = {DATA_WIDTH{1'b0}};
      idx  = {PTR_W{1'b0}};
      for (int k = DEPTH; k >= 1; k--) begin
         idx = tail - PTR_W'(k);
         if (occupied[idx] && (ent_addr[idx] == ld_addr)) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end else begin
            hit  = hit;
            data = data;
         end
      end
   end

endmodule
`endif

// File: rtl/store_commit_buffer.sv
// -----------------------------------------------------------------------------
// store_commit_buffer
// In-order buffer for committed stores. Accepts stores from the store queue
// and drains them one at a time to the data-cache write port with req/ack.
// Optional feature macro: STORE_FWD_EN (store-to-load forwarding lookup).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   st_valid/addr/data    : committed store in; push when st_valid && st_ready
//   st_ready              : buffer not full
//   mem_req/addr/wdata    : registered write request, stable while mem_req
//   mem_ack               : cache accepts the write (used only while mem_req)
//   ld_addr, ld_fwd_hit, ld_fwd_data : forwarding lookup (STORE_FWD_EN only)
//   wb_empty              : nothing buffered or outstanding
//   wb_count              : occupied entries, including the one in flight
// -----------------------------------------------------------------------------
module store_commit_buffer
   import jellycore_mem_pkg::*;
#(
   parameter int WB_DEPTH   = WB_DEPTH_DEFAULT,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      st_valid,
   input  logic [ADDR_WIDTH-1:0]     st_addr,
   input  logic [DATA_WIDTH-1:0]     st_data,
   output logic                      st_ready,
   output logic                      mem_req,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic                      mem_ack,
`ifdef STORE_FWD_EN
   input  logic [ADDR_WIDTH-1:0]     ld_addr,
   output logic                      ld_fwd_hit,
   output logic [DATA_WIDTH-1:0]     ld_fwd_data,
`endif
   output logic                      wb_empty,
   output logic [$clog2(WB_DEPTH):0] wb_count
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] ent_addr [WB_DEPTH];
   logic [DATA_WIDTH-1:0] ent_data [WB_DEPTH];

   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [PTR_W-1:0]      head_inc;
   logic [CNT_W-1:0]      count;

   wb_state_t             state;
   wb_state_t             state_next;
   logic                  req_next;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [DATA_WIDTH-1:0] wdata_next;

   logic                  push;
   logic                  pop;

   // Full + ack does not bypass: st_ready looks only at the registered count.
   assign st_ready = (count != CNT_W'(WB_DEPTH));
   assign push     = st_valid & st_ready;
   assign pop      = (state == WB_REQ) & mem_ack;
   assign head_inc = head + PTR_W'(1);
   assign wb_empty = (count == {CNT_W{1'b0}});
   assign wb_count = count;

   // Entry storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[tail] <= st_addr;
         ent_data[tail] <= st_data;
      end
   end

   // Circular pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= {PTR_W{1'b0}};
         tail  <= {PTR_W{1'b0}};
         count <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head_inc;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Drain FSM state and registered write-port outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= WB_IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= {ADDR_WIDTH{1'b0}};
         mem_wdata <= {DATA_WIDTH{1'b0}};
      end else begin
         state     <= state_next;
         mem_req   <= req_next;
         mem_addr  <= addr_next;
         mem_wdata <= wdata_next;
      end
   end

   // Next-state and next write-port values. count is the registered value, so
   // a store pushed on the same edge as the last ack costs one IDLE cycle.
   always_comb begin
      state_next = state;
      req_next   = mem_req;
      addr_next  = mem_addr;
      wdata_next = mem_wdata;
      case (state)
         WB_IDLE: begin
            if (count != {CNT_W{1'b0}}) begin
               state_next = WB_REQ;
               req_next   = 1'b1;
               addr_next  = ent_addr[head];
               wdata_next = ent_data[head];
            end else begin
               state_next = WB_IDLE;
               req_next   = 1'b0;
            end
         end
         WB_REQ: begin
            if (mem_ack) begin
               if (count > CNT_W'(1)) begin
                  // Back-to-back: present the next entry with no bubble.
                  state_next = WB_REQ;
                  req_next   = 1'b1;
                  addr_next  = ent_addr[head_inc];
                  wdata_next = ent_data[head_inc];
               end else begin
                  state_next = WB_IDLE;
                  req_next   = 1'b0;
               end
            end else begin
               state_next = WB_REQ;
               req_next   = 1'b1;
            end
         end
         default: begin
            state_next = WB_IDLE;
            req_next   = 1'b0;
         end
      endcase
   end

`ifdef STORE_FWD_EN
   logic [WB_DEPTH-1:0] occupied;

   // Entry i is occupied when its distance from head is below count.
   always_comb begin
      occupied = {WB_DEPTH{1'b0}};
      for (int i = 0; i < WB_DEPTH; i++) begin
         occupied[i] = ({1'b0, PTR_W'(i) - head} < count);
      end
   end

   store_fwd_match #(
      .DEPTH      (WB_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fwd (
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .occupied (occupied),
      .tail     (tail),
      .ld_addr  (ld_addr),
      .hit      (ld_fwd_hit),
      .data     (ld_fwd_data)
   );
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_commit_buffer
// Directed, table-driven bench for store_commit_buffer (WB_DEPTH = 4).
// Each table row drives inputs, takes one rising edge and compares the
// outputs 1 ns later against hand-computed values. Reset-mid-request and the
// optional forwarding lookup are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_store_commit_buffer;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic        wb_empty;
   logic [2:0]  wb_count;
`ifdef STORE_FWD_EN
   logic [31:0] ld_addr;
   logic        ld_fwd_hit;
   logic [31:0] ld_fwd_data;
`endif

   int n_cmp;
   int n_fail;

   store_commit_buffer #(
      .WB_DEPTH   (4),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_ready  (st_ready),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
`ifdef STORE_FWD_EN
      .ld_addr     (ld_addr),
      .ld_fwd_hit  (ld_fwd_hit),
      .ld_fwd_data (ld_fwd_data),
`endif
      .wb_empty  (wb_empty),
      .wb_count  (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st_valid;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic        mem_ack;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic        exp_ready;
      logic [2:0]  exp_count;
      logic        exp_empty;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic ack, input logic req, input logic [31:0] ea,
                               input logic [31:0] ed, input logic rdy, input logic [2:0] cnt,
                               input logic emp);
      vec_t r;
      r.st_valid = v;   r.st_addr = a;    r.st_data = d;   r.mem_ack = ack;
      r.exp_req = req;  r.exp_addr = ea;  r.exp_data = ed;
      r.exp_ready = rdy; r.exp_count = cnt; r.exp_empty = emp;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      reset    = 1'b1;
      st_valid = 1'b0;
      st_addr  = 32'h0;
      st_data  = 32'h0;
      mem_ack  = 1'b0;
`ifdef STORE_FWD_EN
      ld_addr  = 32'h0;
`endif

      // ---- single store, ack sampled at edge 5 ----
      vecs.push_back(mk(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 3'd0, 1'b1));
      // ---- back-to-back drain A/B/C, ack tied high ----
      vecs.push_back(mk(1'b1, 32'h10, 32'hAAAA0010, 1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b1, 32'h14, 32'hBBBB0014, 1'b1, 1'b1, 32'h10, 32'hAAAA0010, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b1, 32'h18, 32'hCCCC0018, 1'b1, 1'b1, 32'h14, 32'hBBBB0014, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h18, 32'hCCCC0018, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 3'd0, 1'b1));
      // ---- fill to full, rejected fifth push, ack reopens next cycle ----
      vecs.push_back(mk(1'b1, 32'h300, 32'h00003000, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b1, 32'h304, 32'h00003040, 1'b0, 1'b1, 32'h300, 32'h00003000, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b1, 32'h308, 32'h00003080, 1'b0, 1'b1, 32'h300, 32'h00003000, 1'b1, 3'd3, 1'b0));
      vecs.push_back(mk(1'b1, 32'h30C, 32'h000030C0, 1'b0, 1'b1, 32'h300, 32'h00003000, 1'b0, 3'd4, 1'b0));
      vecs.push_back(mk(1'b1, 32'h3F0, 32'h00003F00, 1'b0, 1'b1, 32'h300, 32'h00003000, 1'b0, 3'd4, 1'b0));
      vecs.push_back(mk(1'b1, 32'h3F0, 32'h00003F00, 1'b1, 1'b1, 32'h304, 32'h00003040, 1'b1, 3'd3, 1'b0));
      vecs.push_back(mk(1'b1, 32'h3F0, 32'h00003F00, 1'b1, 1'b1, 32'h308, 32'h00003080, 1'b1, 3'd3, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h30C, 32'h000030C0, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h3F0, 32'h00003F00, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 3'd0, 1'b1));
      // ---- simultaneous push/pop, tail wraps 3 -> 0 -> 1 ----
      vecs.push_back(mk(1'b1, 32'h500, 32'h55550500, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b1, 32'h504, 32'h55550504, 1'b0, 1'b1, 32'h500, 32'h55550500, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b1, 32'h508, 32'h55550508, 1'b1, 1'b1, 32'h504, 32'h55550504, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b1, 32'h50C, 32'h5555050C, 1'b1, 1'b1, 32'h508, 32'h55550508, 1'b1, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h50C, 32'h5555050C, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 3'd0, 1'b1));
      // ---- push on the last entry's ack: one IDLE cycle, then REQ ----
      vecs.push_back(mk(1'b1, 32'h600, 32'h66660600, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h600, 32'h66660600, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b1, 32'h604, 32'h66660604, 1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h604, 32'h66660604, 1'b1, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 3'd0, 1'b1));

      // ---- reset state ----
      #2;
      check("reset mem_req",   {63'd0, mem_req},  64'd0);
      check("reset mem_addr",  {32'd0, mem_addr}, 64'd0);
      check("reset mem_wdata", {32'd0, mem_wdata}, 64'd0);
      check("reset st_ready",  {63'd0, st_ready}, 64'd1);
      check("reset wb_empty",  {63'd0, wb_empty}, 64'd1);
      check("reset wb_count",  {61'd0, wb_count}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++) begin
         st_valid = vecs[i].st_valid;
         st_addr  = vecs[i].st_addr;
         st_data  = vecs[i].st_data;
         mem_ack  = vecs[i].mem_ack;
         tick();
         check($sformatf("row%0d mem_req", i),  {63'd0, mem_req},  {63'd0, vecs[i].exp_req});
         if (vecs[i].exp_req) begin
            check($sformatf("row%0d mem_addr", i),  {32'd0, mem_addr},  {32'd0, vecs[i].exp_addr});
            check($sformatf("row%0d mem_wdata", i), {32'd0, mem_wdata}, {32'd0, vecs[i].exp_data});
         end
         check($sformatf("row%0d st_ready", i), {63'd0, st_ready}, {63'd0, vecs[i].exp_ready});
         check($sformatf("row%0d wb_count", i), {61'd0, wb_count}, {61'd0, vecs[i].exp_count});
         check($sformatf("row%0d wb_empty", i), {63'd0, wb_empty}, {63'd0, vecs[i].exp_empty});
      end
      st_valid = 1'b0;
      mem_ack  = 1'b0;

      // ---- async reset while a request is outstanding ----
      st_valid = 1'b1; st_addr = 32'h700; st_data = 32'h77770700;
      tick();
      st_addr = 32'h704; st_data = 32'h77770704;
      tick();
      st_valid = 1'b0;
      check("pre-reset mem_req",  {63'd0, mem_req},  64'd1);
      check("pre-reset wb_count", {61'd0, wb_count}, 64'd2);
      #2;
      reset = 1'b1;
      #1;
      check("async reset mem_req",  {63'd0, mem_req},  64'd0);
      check("async reset wb_count", {61'd0, wb_count}, 64'd0);
      check("async reset st_ready", {63'd0, st_ready}, 64'd1);
      check("async reset wb_empty", {63'd0, wb_empty}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("post-reset cycle%0d mem_req", c), {63'd0, mem_req}, 64'd0);
      end

`ifdef STORE_FWD_EN
      // ---- forwarding: youngest match wins, in-flight entry included ----
      st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h1111;
      tick();
      st_data = 32'h2222;
      tick();
      st_valid = 1'b0;
      ld_addr  = 32'h200;
      #1;
      check("fwd hit 0x200",  {63'd0, ld_fwd_hit},  64'd1);
      check("fwd data 0x200", {32'd0, ld_fwd_data}, 64'h2222);
      ld_addr = 32'h204;
      #1;
      check("fwd hit 0x204",  {63'd0, ld_fwd_hit},  64'd0);
      check("fwd data 0x204", {32'd0, ld_fwd_data}, 64'd0);
      mem_ack = 1'b1;
      tick();
      tick();
      mem_ack = 1'b0;
      check("fwd drain wb_empty", {63'd0, wb_empty}, 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
